// File: rtl/pwm_fader_pkg.sv
// Shared types and helpers for the pwm_fader duty sequencer.
// Holds the FSM encoding, the clamped duty step, and the gamma curve used with PWM_FADER_GAMMA_EN.
package pwm_fader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } fader_state_e;

    // Moves cur toward tgt by at most step. The difference is one bit wider than the operands,
    // and the move is clamped to that difference, so the result never overshoots or wraps.
    // Operands are zero-extended to 32 bits, so the fader WIDTH must be 32 or less.
    function automatic logic [31:0] next_duty(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
        logic [32:0] diff;
        logic [31:0] mag;
        if (tgt > cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            mag  = (diff > {1'b0, step}) ? step : diff[31:0];
            return cur + mag;
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
            mag  = (diff > {1'b0, step}) ? step : diff[31:0];
            return cur - mag;
        end
    endfunction

    // Quadratic perceptual curve (x*x) >> w. Full scale maps to full scale, so a
    // fully-on fade really ends fully on.
    function automatic logic [31:0] gamma(input logic [31:0] x, input int w);
        logic [63:0] sq;
        sq = {32'd0, x} * {32'd0, x};
        if (x == ((32'd1 << w) - 32'd1)) begin
            return x;
        end
        return 32'(sq >> w);
    endfunction

endpackage

// File: rtl/pwm_fader_pwm.sv
// The pwm block: a free-running WIDTH-bit accumulator with a registered output.
// ARCH==1 is a first-order delta-sigma modulator. Any other value gives a counter/comparator.
module pwm #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic [WIDTH-1:0] i_x,
    output logic             o_y,
    output logic [WIDTH-1:0] o_acc
);

    logic [WIDTH:0] ds_sum;

    assign ds_sum = {1'b0, o_acc} + {1'b0, i_x};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_acc <= '0;
            o_y   <= 1'b0;
        end else if (i_cg) begin
            if (ARCH == 1) begin
                o_acc <= ds_sum[WIDTH-1:0];
                o_y   <= ds_sum[WIDTH];
            end else begin
                // Comparator: during the cycle in which acc==k, y is loaded with (k < x).
                // Over one period, y is therefore high for exactly x cycles.
                o_acc <= o_acc + WIDTH'(1);
                o_y   <= (o_acc < i_x);
            end
        end
    end

endmodule

// File: rtl/pwm_fader.sv
// Duty-cycle sequencer that ramps one pwm instance toward a requested duty, one period boundary at a time.
// Optional macro PWM_FADER_GAMMA_EN feeds gamma(o_x) to the pwm instead of the linear duty.
module pwm_fader
    import pwm_fader_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ARCH   = 0,
    parameter int STEP   = 1,
    parameter int RATE_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cg,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WIDTH-1:0]  i_target,
    input  logic [RATE_W-1:0] i_rate,
    output logic              o_busy,
    output logic              o_done,
    output logic [WIDTH-1:0]  o_x,
    output logic              o_y
);

    fader_state_e      state, state_n;
    logic [WIDTH-1:0]  x_q, x_n, x_step;
    logic [WIDTH-1:0]  tgt_q, tgt_n;
    logic [RATE_W-1:0] rate_q, rate_n;
    logic [RATE_W-1:0] presc_q, presc_n;
    logic              done_q, done_n;
    logic              tick;
    logic              accept;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  duty;

    // Handshake: a request transfers on a rising edge where i_valid, o_ready and i_cg are all high.
    // o_ready depends only on state (high in IDLE). A requester may drop i_valid at any time
    // without effect, and requests presented during RAMP are never taken.
    assign o_ready = (state == IDLE);
    assign o_busy  = (state == RAMP);
    assign o_done  = done_q;
    assign o_x     = x_q;
    assign accept  = i_valid & o_ready & i_cg;

    assign x_step = WIDTH'(next_duty(32'(x_q), 32'(tgt_q), 32'(STEP)));

    generate
        if (ARCH == 1) begin : g_ds_tick
            // The delta-sigma accumulator has no fixed wrap point, so a shadow counter marks the period cadence.
            logic [WIDTH-1:0] period_cnt;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    period_cnt <= '0;
                end else if (i_cg) begin
                    period_cnt <= period_cnt + WIDTH'(1);
                end
            end
            assign tick = (&period_cnt) & i_cg;
        end else begin : g_cmp_tick
            assign tick = (&acc) & i_cg;
        end
    endgenerate

    always_comb begin
        state_n = state;
        x_n     = x_q;
        tgt_n   = tgt_q;
        rate_n  = rate_q;
        presc_n = presc_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (i_target == x_q) begin
                        done_n = 1'b1;
                    end else begin
                        tgt_n   = i_target;
                        rate_n  = i_rate;
                        presc_n = '0;
                        state_n = RAMP;
                    end
                end
            end
            RAMP: begin
                // o_x only moves on the last cycle of a period, so the pwm picks it up at acc==0.
                if (tick) begin
                    if (presc_q == rate_q) begin
                        x_n     = x_step;
                        presc_n = '0;
                        if (x_step == tgt_q) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        presc_n = presc_q + RATE_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            x_q     <= '0;
            tgt_q   <= '0;
            rate_q  <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else if (i_cg) begin
            state   <= state_n;
            x_q     <= x_n;
            tgt_q   <= tgt_n;
            rate_q  <= rate_n;
            presc_q <= presc_n;
            done_q  <= done_n;
        end
    end

`ifdef PWM_FADER_GAMMA_EN
    // The curve is registered from the incoming duty on the tick cycle. It therefore reaches
    // the pwm at the same period start as the linear o_x update.
    logic [WIDTH-1:0] gamma_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gamma_q <= '0;
        end else if (tick) begin
            gamma_q <= WIDTH'(gamma(32'(x_n), WIDTH));
        end
    end
    assign duty = gamma_q;
`else
    assign duty = x_q;
`endif

    pwm #(
        .WIDTH(WIDTH),
        .ARCH (ARCH)
    ) u_pwm (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_cg (i_cg),
        .i_x  (duty),
        .o_y  (o_y),
        .o_acc(acc)
    );

endmodule

// File: tb/tb_pwm_fader.sv
// Scoreboard bench for pwm_fader: two WIDTH=4 instances (STEP=3 and STEP=4) driven by directed ramps.
// Expected o_x changes, o_done pulses, their spacing and per-period PWM high counts are queued ahead.
module tb_pwm_fader;

    typedef struct {
        int       id;
        logic     is_done;
        logic [3:0] x;
        int       gap;
        int       at;
        int       ycnt;
    } ev_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic       rst_a, cg_a, valid_a;
    logic [3:0] target_a, rate_a;
    logic       ready_a, busy_a, done_a, y_a;
    logic [3:0] x_a;

    logic       rst_b, cg_b, valid_b;
    logic [3:0] target_b, rate_b;
    logic       ready_b, busy_b, done_b, y_b;
    logic [3:0] x_b;

    ev_t        exp_q[$];
    logic       mon_en = 1'b0;
    logic [3:0] prev_x[2];
    int         ywin[2];
    int         yacc[2];
    int         yexp[2];
    int         last_ev = 0;

    pwm_fader #(.WIDTH(4), .ARCH(0), .STEP(3), .RATE_W(4)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_cg(cg_a), .i_valid(valid_a), .o_ready(ready_a),
        .i_target(target_a), .i_rate(rate_a), .o_busy(busy_a), .o_done(done_a),
        .o_x(x_a), .o_y(y_a)
    );

    pwm_fader #(.WIDTH(4), .ARCH(0), .STEP(4), .RATE_W(4)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_cg(cg_b), .i_valid(valid_b), .o_ready(ready_b),
        .i_target(target_b), .i_rate(rate_b), .o_busy(busy_b), .o_done(done_b),
        .o_x(x_b), .o_y(y_b)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic int y_model(input logic [3:0] v);
`ifdef PWM_FADER_GAMMA_EN
        if (v == 4'd15) return 15;
        return (int'(v) * int'(v)) / 16;
`else
        return int'(v);
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_x(input int id, input logic [3:0] v, input int gap, input int at);
        ev_t e;
        e.id = id; e.is_done = 1'b0; e.x = v; e.gap = gap; e.at = at; e.ycnt = y_model(v);
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int id, input int gap, input int at);
        ev_t e;
        e.id = id; e.is_done = 1'b1; e.x = 4'd0; e.gap = gap; e.at = at; e.ycnt = 0;
        exp_q.push_back(e);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic take_event(input int id, input logic is_done, input logic [3:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected dut%0d %s x=%0d at cycle %0d", id,
                     is_done ? "done" : "x-change", v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.id != id || e.is_done != is_done || (!is_done && e.x != v) ||
                (e.gap >= 0 && (cyc - last_ev) != e.gap) || (e.at >= 0 && cyc != e.at)) begin
                errors++;
                $display("FAIL event: got dut%0d %s x=%0d cyc=%0d gap=%0d; expected dut%0d %s x=%0d gap=%0d at=%0d",
                         id, is_done ? "done" : "x-change", v, cyc, cyc - last_ev,
                         e.id, e.is_done ? "done" : "x-change", e.x, e.gap, e.at);
            end
            if (!is_done) begin
                ywin[id] = 16;
                yacc[id] = 0;
                yexp[id] = e.ycnt;
            end
        end
        last_ev = cyc;
    endtask

    always @(negedge clk) begin
        logic [3:0] xs[2];
        logic       ds[2];
        logic       ys[2];
        if (mon_en) begin
            xs[0] = x_a; ds[0] = done_a; ys[0] = y_a;
            xs[1] = x_b; ds[1] = done_b; ys[1] = y_b;
            for (int d = 0; d < 2; d++) begin
                if (xs[d] != prev_x[d]) take_event(d, 1'b0, xs[d]);
                if (ds[d]) take_event(d, 1'b1, 4'd0);
                prev_x[d] = xs[d];
                if (ywin[d] > 0) begin
                    if (ys[d]) yacc[d]++;
                    ywin[d]--;
                    if (ywin[d] == 0) begin
                        checks++;
                        if (yacc[d] != yexp[d]) begin
                            errors++;
                            $display("FAIL y_high_count dut%0d: got %0d, expected %0d (cycle %0d)",
                                     d, yacc[d], yexp[d], cyc);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int id, input logic [3:0] tgt, input logic [3:0] rate);
        @(negedge clk);
        if (id == 0) begin
            check("ready_a before request", int'(ready_a), 1);
            valid_a = 1'b1; target_a = tgt; rate_a = rate;
        end else begin
            check("ready_b before request", int'(ready_b), 1);
            valid_b = 1'b1; target_b = tgt; rate_b = rate;
        end
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_x(input int id, input logic [3:0] v, input int limit);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if ((id == 0 ? x_a : x_b) == v) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_x dut%0d: x never reached %0d within %0d cycles", id, v, limit);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drained in time", exp_q.size(), 0);
        exp_q.delete();
        repeat (18) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_a = 1'b1; cg_a = 1'b1; valid_a = 1'b0; target_a = '0; rate_a = '0;
        rst_b = 1'b1; cg_b = 1'b1; valid_b = 1'b0; target_b = '0; rate_b = '0;
        ywin[0] = 0; ywin[1] = 0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        prev_x[0] = 4'd0;
        prev_x[1] = 4'd0;
        mon_en = 1'b1;

        // Reset then idle for four periods: x=0, ready=1, busy=0, y=0 packed as 7'b0000_100.
        repeat (64) begin
            @(negedge clk);
            check("idle_a {x,ready,busy,y}", int'({x_a, ready_a, busy_a, y_a}), 4);
        end
        check("idle_b {x,ready,busy,y}", int'({x_b, ready_b, busy_b, y_b}), 4);

        // Up-ramp 0 -> 10, STEP=3, rate 0: 3,6,9,10 one period apart.
        push_x(0, 4'd3, -1, -1);
        push_x(0, 4'd6, 16, -1);
        push_x(0, 4'd9, 16, -1);
        push_x(0, 4'd10, 16, -1);
        push_done(0, 0, -1);
        send(0, 4'd10, 4'd0);
        drain(200);

        // STEP=4 instance: 0 -> 10 (4,8,10), then down to 1 at rate 2 (6,2,1, three periods apart).
        push_x(1, 4'd4, -1, -1);
        push_x(1, 4'd8, 16, -1);
        push_x(1, 4'd10, 16, -1);
        push_done(1, 0, -1);
        send(1, 4'd10, 4'd0);
        drain(200);
        push_x(1, 4'd6, -1, -1);
        push_x(1, 4'd2, 48, -1);
        push_x(1, 4'd1, 48, -1);
        push_done(1, 0, -1);
        send(1, 4'd1, 4'd2);
        drain(400);

        // 10 -> 5 with a clamped last step, then a request equal to the current duty.
        push_x(0, 4'd7, -1, -1);
        push_x(0, 4'd5, 16, -1);
        push_done(0, 0, -1);
        send(0, 4'd5, 4'd0);
        drain(200);
        @(negedge clk);
        push_done(0, -1, cyc + 1);
        valid_a = 1'b1; target_a = 4'd5; rate_a = 4'd0;
        @(negedge clk);
        valid_a = 1'b0;
        check("busy after equal-target accept", int'(busy_a), 0);
        check("ready after equal-target accept", int'(ready_a), 1);
        drain(50);

        // Reset back to 0, then ramp 0 -> 15 while a second request is held (never acknowledged).
        @(negedge clk);
        push_x(0, 4'd0, -1, cyc + 1);
        rst_a = 1'b1;
        @(negedge clk);
        check("busy in reset", int'(busy_a), 0);
        check("ready in reset", int'(ready_a), 1);
        rst_a = 1'b0;
        push_x(0, 4'd3, -1, -1);
        push_x(0, 4'd6, 16, -1);
        push_x(0, 4'd9, 16, -1);
        push_x(0, 4'd12, 16, -1);
        push_x(0, 4'd15, 16, -1);
        push_done(0, 0, -1);
        send(0, 4'd15, 4'd0);
        wait_x(0, 4'd3, 100);
        repeat (2) @(negedge clk);
        valid_a = 1'b1; target_a = 4'd2; rate_a = 4'd0;
        repeat (8) begin
            @(negedge clk);
            check("ready while ramping", int'(ready_a), 0);
        end
        valid_a = 1'b0;
        drain(300);

        // 15 -> 3 at rate 1 with the clock gate low for 20 cycles between the first and second steps.
        push_x(0, 4'd12, -1, -1);
        push_x(0, 4'd9, 52, -1);
        push_x(0, 4'd6, 32, -1);
        push_x(0, 4'd3, 32, -1);
        push_done(0, 0, -1);
        send(0, 4'd3, 4'd1);
        wait_x(0, 4'd12, 100);
        repeat (20) @(negedge clk);
        cg_a = 1'b0;
        repeat (20) @(negedge clk);
        check("busy held while gated", int'(busy_a), 1);
        cg_a = 1'b1;
        drain(400);

        // 3 -> 1 (clamped), then 1 -> 13 at rate 1, reset while x=7.
        push_x(0, 4'd1, -1, -1);
        push_done(0, 0, -1);
        send(0, 4'd1, 4'd0);
        drain(200);
        push_x(0, 4'd4, -1, -1);
        push_x(0, 4'd7, 32, -1);
        send(0, 4'd13, 4'd1);
        wait_x(0, 4'd7, 200);
        repeat (20) @(negedge clk);
        push_x(0, 4'd0, -1, cyc + 1);
        rst_a = 1'b1;
        @(negedge clk);
        check("busy after mid-ramp reset", int'(busy_a), 0);
        check("ready after mid-ramp reset", int'(ready_a), 1);
        rst_a = 1'b0;
        repeat (80) @(negedge clk);
        check("no stray events after reset", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
